// File: rtl/mul_fifo_pkg.sv
// Shared definitions for the multiplier result FIFO and its read-side drain.
// Holds the drain FSM state encoding and the FIFO status codes.
package mul_fifo_pkg;

    // Drain FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_OUT  = ST_OUT
    } drain_state_t;

    // FIFO-side status codes
    localparam logic [2:0] FIFO_INIT     = 3'd0;
    localparam logic [2:0] FIFO_NO_OP    = 3'd1;
    localparam logic [2:0] FIFO_WRITE    = 3'd2;
    localparam logic [2:0] FIFO_WR_ERROR = 3'd3;
    localparam logic [2:0] FIFO_READ     = 3'd4;
    localparam logic [2:0] FIFO_RD_ERROR = 3'd5;

    typedef enum logic [2:0] {
        F_INIT     = FIFO_INIT,
        F_NO_OP    = FIFO_NO_OP,
        F_WRITE    = FIFO_WRITE,
        F_WR_ERROR = FIFO_WR_ERROR,
        F_READ     = FIFO_READ,
        F_RD_ERROR = FIFO_RD_ERROR
    } fifo_state_t;

endpackage

// File: rtl/mul_fifo_drain_cnt.sv
// Event counter for the FIFO drain: clears, increments, wraps or saturates.
// Ports: clk, reset (sync, high), clear, inc -> count[CNT_W-1:0].
module mul_fifo_drain_cnt #(
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            // clear beats a same-cycle increment
            count <= '0;
        end else if (inc) begin
            if (SATURATE && (&count)) begin
                count <= count;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mul_fifo_drain.sv
// Read-side master for the multiplier result FIFO: one outstanding read,
// captured data offered on a valid/ready port, read/error counters, fault.
// Ports: clk, reset; enable, clear; fifo_empty/rd_en/rd_ack/rd_err/dout;
// out_valid/out_ready/out_data; rd_count, err_count, fault.
module mul_fifo_drain
    import mul_fifo_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              fault
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    drain_state_t     state;
    drain_state_t     state_nxt;
    logic [TMR_W-1:0] timer;
    logic             start;
    logic             rd_inc;
    logic             err_inc;
    logic             timeout;
    logic             handshake;

    assign start     = enable & ~fifo_empty & ~fault;
    assign handshake = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        rd_inc    = 1'b0;
        err_inc   = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // ack wins when ack and err arrive together
                if (fifo_rd_ack) begin
                    rd_inc    = 1'b1;
                    state_nxt = S_OUT;
                end else if (fifo_rd_err) begin
                    err_inc   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (timer == TMR_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                if (handshake) begin
                    state_nxt = start ? S_REQ : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            fifo_rd_en <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            timer      <= '0;
            fault      <= 1'b0;
        end else begin
            state <= state_nxt;
            // registered strobe, high exactly while in REQ
            fifo_rd_en <= (state_nxt == S_REQ);

            if (state == S_REQ) begin
                timer <= '0;
            end else if (state == S_WAIT) begin
                timer <= timer + TMR_W'(1);
            end

            if (rd_inc) begin
                out_valid <= 1'b1;
                out_data  <= fifo_dout;
            end else if ((state == S_OUT) && handshake) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                fault <= 1'b0;
            end else if (timeout) begin
                fault <= 1'b1;
            end
        end
    end

    mul_fifo_drain_cnt #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b0)
    ) u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (rd_inc),
        .count (rd_count)
    );

    mul_fifo_drain_cnt #(
        .CNT_W    (CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_mul_fifo_drain.sv
// Self-checking bench for mul_fifo_drain: directed scenarios plus a
// randomized run against a transaction-level scoreboard.
module tb_mul_fifo_drain;

    localparam int DATA_W  = 64;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              clear;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              fifo_rd_ack;
    logic              fifo_rd_err;
    logic [DATA_W-1:0] fifo_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  err_count;
    logic              fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_fifo_drain #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .fifo_dout   (fifo_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .rd_count    (rd_count),
        .err_count   (err_count),
        .fault       (fault)
    );

    task automatic idle_inputs();
        enable      = 1'b0;
        clear       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        fifo_dout   = '0;
        out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // waits (bounded) for a read strobe; returns at the REQ-cycle negedge
    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (fifo_rd_en === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit bad_en;
        do_reset();
        fifo_empty = 1'b0;
        bad_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_en = 1'b1;
        end
        checks++;
        if (bad_en !== 1'b0)
            begin errors++; $display("FAIL reset_rd_en: got strobe, want none"); end
        checks++;
        if ({out_valid, out_data, rd_count, err_count, fault} !== '0)
            begin errors++; $display("FAIL reset_outputs: got v=%b d=%h rc=%0d ec=%0d f=%b want all 0",
                out_valid, out_data, rd_count, err_count, fault); end
    endtask

    task automatic test_single_read();
        bit found;
        enable = 1'b1; fifo_empty = 1'b0; out_ready = 1'b1;
        wait_req(found);
        checks++;
        if (found !== 1'b1)
            begin errors++; $display("FAIL single_req: got no rd_en, want rd_en"); end
        fifo_empty = 1'b1;
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, out_valid} !== 2'b00)
            begin errors++; $display("FAIL single_wait: got rd_en=%b v=%b want 0 0", fifo_rd_en, out_valid); end
        fifo_rd_ack = 1'b1; fifo_dout = 64'h1234;
        @(negedge clk);
        fifo_rd_ack = 1'b0; fifo_dout = '0;
        checks++;
        if ({out_valid, out_data, rd_count} !== {1'b1, 64'h1234, 4'd1})
            begin errors++; $display("FAIL single_out: got v=%b d=%h rc=%0d want 1 1234 1",
                out_valid, out_data, rd_count); end
        @(negedge clk);
        checks++;
        if ({out_valid, fifo_rd_en} !== 2'b00)
            begin errors++; $display("FAIL single_done: got v=%b rd_en=%b want 0 0", out_valid, fifo_rd_en); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        bit found;
        bit bad;
        int hs;
        logic [DATA_W-1:0] w;
        w = {$urandom, $urandom};
        pulse_clear();
        enable = 1'b1; fifo_empty = 1'b0; out_ready = 1'b0;
        wait_req(found);
        checks++;
        if (found !== 1'b1)
            begin errors++; $display("FAIL bp_req: got no rd_en, want rd_en"); end
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_rd_ack = 1'b1; fifo_dout = w;
        @(negedge clk);
        fifo_rd_ack = 1'b0; fifo_dout = '0;
        bad = 1'b0; hs = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b1 || out_data !== w || fifo_rd_en !== 1'b0) bad = 1'b1;
            out_ready = (i == 5);
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0)
            begin errors++; $display("FAIL bp_stable: got d=%h, want %h held with v=1", out_data, w); end
        for (int i = 0; i < 5; i++) begin
            if (out_valid && out_ready) hs++;
            if (fifo_rd_en !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (hs != 1 || bad !== 1'b0)
            begin errors++; $display("FAIL bp_once: got hs=%0d extra_req=%b want 1 0", hs, bad); end
        checks++;
        if (rd_count !== 4'd1)
            begin errors++; $display("FAIL bp_count: got %0d want 1", rd_count); end
        enable = 1'b0;
    endtask

    task automatic test_priority();
        bit found;
        pulse_clear();
        enable = 1'b1; fifo_empty = 1'b0; out_ready = 1'b0;
        wait_req(found);
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_rd_ack = 1'b1; fifo_rd_err = 1'b1; fifo_dout = 64'hA5A5;
        @(negedge clk);
        fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0;
        checks++;
        if ({found, out_valid, out_data, rd_count, err_count} !== {2'b11, 64'hA5A5, 4'd1, 4'd0})
            begin errors++; $display("FAIL ack_prio: got req=%b v=%b d=%h rc=%0d ec=%0d want 1 1 a5a5 1 0",
                found, out_valid, out_data, rd_count, err_count); end
        out_ready = 1'b1;
        fifo_empty = 1'b0;
        wait_req(found);
        out_ready = 1'b0; fifo_empty = 1'b1;
        @(negedge clk);
        fifo_rd_ack = 1'b1; fifo_dout = 64'h77; clear = 1'b1;
        @(negedge clk);
        fifo_rd_ack = 1'b0; clear = 1'b0;
        checks++;
        if ({found, out_valid, out_data, rd_count} !== {2'b11, 64'h77, 4'd0})
            begin errors++; $display("FAIL clear_prio: got req=%b v=%b d=%h rc=%0d want 1 1 77 0",
                found, out_valid, out_data, rd_count); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; enable = 1'b0;
    endtask

    task automatic test_err_saturate();
        bit found;
        bit bad_v;
        bit bad_c;
        int exp;
        bad_v = 1'b0; bad_c = 1'b0;
        pulse_clear();
        out_ready = 1'b1; fifo_empty = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            enable = 1'b1;
            wait_req(found);
            if (!found) bad_c = 1'b1;
            enable = 1'b0;
            @(negedge clk);
            fifo_rd_err = 1'b1;
            @(negedge clk);
            fifo_rd_err = 1'b0;
            exp = (k > CNT_MAX) ? CNT_MAX : k;
            if (out_valid !== 1'b0) bad_v = 1'b1;
            if (err_count !== CNT_W'(exp) || rd_count !== '0) bad_c = 1'b1;
        end
        checks++;
        if (bad_v !== 1'b0)
            begin errors++; $display("FAIL err_no_valid: got out_valid=1, want 0"); end
        checks++;
        if (bad_c !== 1'b0 || err_count !== 4'd15)
            begin errors++; $display("FAIL err_sat: got ec=%0d want 15", err_count); end
        fifo_empty = 1'b1;
    endtask

    task automatic test_timeout();
        bit found;
        bit early;
        bit bad_en;
        enable = 1'b1; fifo_empty = 1'b0;
        wait_req(found);
        enable = 1'b0;
        early = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (fault !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({found, early, fault} !== 3'b101)
            begin errors++; $display("FAIL timeout_fault: got req=%b early=%b f=%b want 1 0 1",
                found, early, fault); end
        enable = 1'b1; bad_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fifo_rd_ack = (i == 3);
            fifo_rd_err = (i == 6);
            @(negedge clk);
            if (fifo_rd_en !== 1'b0) bad_en = 1'b1;
        end
        fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0;
        checks++;
        if (bad_en !== 1'b0 || rd_count !== 4'd0 || err_count !== 4'd15)
            begin errors++; $display("FAIL fault_block: got req=%b rc=%0d ec=%0d want 0 0 15",
                bad_en, rd_count, err_count); end
        enable = 1'b0;
        pulse_clear();
        checks++;
        if ({fault, rd_count, err_count} !== '0)
            begin errors++; $display("FAIL clear_all: got f=%b rc=%0d ec=%0d want 0 0 0",
                fault, rd_count, err_count); end
        enable = 1'b1;
        wait_req(found);
        enable = 1'b0;
        checks++;
        if (found !== 1'b1)
            begin errors++; $display("FAIL unblock: got no rd_en, want rd_en"); end
        @(negedge clk);
        fifo_rd_err = 1'b1;
        @(negedge clk);
        fifo_rd_err = 1'b0; fifo_empty = 1'b1;
    endtask

    task automatic test_reset_in_out();
        bit found;
        enable = 1'b1; fifo_empty = 1'b0; out_ready = 1'b0;
        wait_req(found);
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_rd_ack = 1'b1; fifo_dout = 64'hDEAD;
        @(negedge clk);
        fifo_rd_ack = 1'b0;
        checks++;
        if ({found, out_valid, rd_count, err_count} !== {2'b11, 4'd1, 4'd1})
            begin errors++; $display("FAIL pre_reset: got req=%b v=%b rc=%0d ec=%0d want 1 1 1 1",
                found, out_valid, rd_count, err_count); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; enable = 1'b0;
        checks++;
        if ({out_valid, out_data, rd_count, err_count, fifo_rd_en} !== '0)
            begin errors++; $display("FAIL reset_out: got v=%b d=%h rc=%0d ec=%0d want all 0",
                out_valid, out_data, rd_count, err_count); end
        out_ready = 1'b1; fifo_empty = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, fifo_rd_en} !== 2'b00)
            begin errors++; $display("FAIL reset_idle: got v=%b rd_en=%b want 0 0", out_valid, fifo_rd_en); end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_q[$];
        int rd_exp;
        int err_exp;
        bit pending;
        int wait_n;
        bit prev_start;
        int kind;
        int n_cyc;
        n_cyc = 800;
        do_reset();
        rd_exp = 0; err_exp = 0; pending = 1'b0; wait_n = 0; prev_start = 1'b0;
        for (int cyc = 0; cyc < n_cyc + 30; cyc++) begin
            @(negedge clk);
            checks++;
            if (rd_count !== CNT_W'(rd_exp) || err_count !== CNT_W'(err_exp))
                begin errors++; $display("FAIL rnd_counts @%0d: got rc=%0d ec=%0d want %0d %0d",
                    cyc, rd_count, err_count, rd_exp, err_exp); end
            if (out_valid && exp_q.size() == 0)
                begin checks++; errors++; $display("FAIL rnd_spurious_valid @%0d: got v=1 want 0", cyc); end
            fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0;
            if (pending) begin
                if (wait_n == 0) begin
                    pending = 1'b0;
                    fifo_dout = {$urandom, $urandom};
                    kind = $urandom_range(0, 9);
                    if (kind < 2) begin
                        fifo_rd_err = 1'b1;
                        if (err_exp < CNT_MAX) err_exp++;
                    end else begin
                        fifo_rd_ack = 1'b1;
                        fifo_rd_err = (kind == 2);
                        exp_q.push_back(fifo_dout);
                        rd_exp = (rd_exp + 1) % (CNT_MAX + 1);
                    end
                end else begin
                    wait_n--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                fifo_rd_ack = $urandom_range(0, 1) == 1;
                fifo_rd_err = !fifo_rd_ack;
                fifo_dout = {$urandom, $urandom};
            end
            if (fifo_rd_en === 1'b1) begin
                checks++;
                if (pending || exp_q.size() != 0 || !prev_start)
                    begin errors++; $display("FAIL rnd_req @%0d: got rd_en pend=%0b q=%0d start=%0b want 0 0 1",
                        cyc, pending, exp_q.size(), prev_start); end
                pending = 1'b1;
                wait_n = $urandom_range(0, 2);
            end
            out_ready = (cyc >= n_cyc) || ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                checks++;
                if (out_data !== exp_q[0])
                    begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", cyc, out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            enable = (cyc < n_cyc) && ($urandom_range(0, 3) != 0);
            fifo_empty = $urandom_range(0, 3) == 0;
            prev_start = enable && !fifo_empty;
        end
        checks++;
        if (exp_q.size() != 0 || pending || out_valid !== 1'b0)
            begin errors++; $display("FAIL rnd_drain: got q=%0d pend=%0b v=%b want 0 0 0",
                exp_q.size(), pending, out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_backpressure();
        test_priority();
        test_err_saturate();
        test_timeout();
        test_reset_in_out();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
